hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding-select unit for the in-order pipeline. It replaces the per-stage combinational forwarding instances with one scoreboard. The scoreboard tracks every in-flight register writer from EX through WB in a shift structure of DEPTH slots. For the instruction in decode it computes a load-use stall and registered EX-stage operand forward selects. It honours the global data-memory stall and branch flushes, and counts load-use stall cycles for performance debug.

---
 rtl/hazard_scoreboard_pkg.sv | 46 ++++
 rtl/hs_match.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_pkg
//  Description : Shared pipeline definitions for the hazard scoreboard.
//                Provides the in-flight slot record, the "read from register
//                file" forward code, and the ready-slot/forward-code helpers.
//                The register file is write-through: a value written in WB is
//                visible to a same-cycle decode read. A writer already in WB
//                at decode time therefore never needs a forward.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Destination/source numbers are stored zero-extended to this width.
    // Register address widths up to 8 bits (256 registers) fit.
    localparam int c_RD_W   = 8;

    // Forward code meaning "take the operand from the register file".
    localparam int c_FWD_RF = 0;

    typedef struct packed {
        logic              v;
        logic              wr;
        logic [c_RD_W-1:0] rd;
        logic              load;
    } slot_t;

    // First slot whose output carries the writer's result.
    function automatic int ready_slot(input logic is_load, input int load_slot);
        return is_load ? load_slot : 1;
    endfunction

    // Hazard when the youngest matching writer is still short of its ready slot.
    function automatic logic is_hazard(input logic hit, input int slot,
                                       input logic is_load, input int load_slot);
        return hit && ((slot + 1) < ready_slot(is_load, load_slot));
    endfunction

    // By the time the consumer reaches EX the writer has moved one slot on.
    // Past the last slot the write-through register file serves the value.
    function automatic int fwd_code(input logic hit, input int slot, input int depth);
        return (hit && ((slot + 1) <= (depth - 1))) ? (slot + 1) : c_FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_match.sv
`default_nettype none
// ============================================================================
//  Module      : hs_match
//  Description : Priority match of one source operand against all tracked
//                in-flight writers. The lowest-indexed (youngest) matching
//                slot wins.
//  Ports       : i_slots      tracked slot records, index 0 = EX
//                i_src_valid  operand is a register read
//                i_src        operand register number (zero-extended)
//                o_hit        some valid writer targets the operand
//                o_slot       index of the youngest matching slot
//                o_load       that writer is a load
//  Revision    : 1.0  initial release
// ============================================================================
module hs_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  slot_t [DEPTH-1:0]         i_slots,
    input  logic                      i_src_valid,
    input  logic [c_RD_W-1:0]         i_src,
    output logic                      o_hit,
    output logic [$clog2(DEPTH)-1:0]  o_slot,
    output logic                      o_load
);

    localparam int SW = $clog2(DEPTH);

    // Scan oldest to youngest so the youngest match is the final assignment.
    always_comb begin
        o_hit  = 1'b0;
        o_slot = '0;
        o_load = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_src_valid && i_slots[i].v && i_slots[i].wr &&
                (i_slots[i].rd == i_src)) begin
                o_hit  = 1'b1;
                o_slot = SW'(i);
                o_load = i_slots[i].load;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tracks in-flight register writers from EX to WB in a DEPTH
//                slot shift array, raises the load-use stall for the decode
//                instruction and registers its EX operand forward selects.
//                mem_stall freezes all state; flush keeps the decode
//                instruction out of the pipe without stalling.
//  Ports       : clk, rst                     clock, synchronous reset
//                issue_valid/wr/rd/load       decode instruction
//                src_a/b_valid, src_a/b       decode operands
//                mem_stall, flush             global freeze, decode kill
//                stall                        combinational load-use stall
//                fwd_a, fwd_b                 registered EX forward selects
//                stall_cnt                    saturating stall cycle count
//                err                          sticky out-of-range rd flag
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS     = 8,
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_wr,
    input  logic [$clog2(NREGS)-1:0]   issue_rd,
    input  logic                       issue_load,
    input  logic                       src_a_valid,
    input  logic                       src_b_valid,
    input  logic [$clog2(NREGS)-1:0]   src_a,
    input  logic [$clog2(NREGS)-1:0]   src_b,
    input  logic                       mem_stall,
    input  logic                       flush,
    output logic                       stall,
    output logic [$clog2(DEPTH)-1:0]   fwd_a,
    output logic [$clog2(DEPTH)-1:0]   fwd_b,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic                       err
);

    localparam int FW = $clog2(DEPTH);

    slot_t [DEPTH-1:0]  r_slots;
    logic  [FW-1:0]     r_fwd_a;
    logic  [FW-1:0]     r_fwd_b;
    logic  [CNT_W-1:0]  r_stall_cnt;
    logic               r_err;

    logic               w_hit_a, w_hit_b;
    logic               w_load_a, w_load_b;
    logic  [FW-1:0]     w_slot_a, w_slot_b;
    logic               w_stall;
    logic               w_enter;
    logic  [FW-1:0]     w_code_a, w_code_b;
    slot_t              w_new_slot;

    hs_match #(.DEPTH(DEPTH)) u_match_a (
        .i_slots     (r_slots),
        .i_src_valid (src_a_valid),
        .i_src       (c_RD_W'(src_a)),
        .o_hit       (w_hit_a),
        .o_slot      (w_slot_a),
        .o_load      (w_load_a)
    );

    hs_match #(.DEPTH(DEPTH)) u_match_b (
        .i_slots     (r_slots),
        .i_src_valid (src_b_valid),
        .i_src       (c_RD_W'(src_b)),
        .o_hit       (w_hit_b),
        .o_slot      (w_slot_b),
        .o_load      (w_load_b)
    );

    always_comb begin
        w_stall = issue_valid && !flush &&
                  (is_hazard(w_hit_a, int'(w_slot_a), w_load_a, LOAD_SLOT) ||
                   is_hazard(w_hit_b, int'(w_slot_b), w_load_b, LOAD_SLOT));
        w_enter  = issue_valid && !w_stall && !flush;
        w_code_a = FW'(fwd_code(w_hit_a, int'(w_slot_a), DEPTH));
        w_code_b = FW'(fwd_code(w_hit_b, int'(w_slot_b), DEPTH));

        w_new_slot = '0;
        if (w_enter) begin
            w_new_slot.v    = 1'b1;
            w_new_slot.wr   = issue_wr;
            w_new_slot.rd   = c_RD_W'(issue_rd);
            w_new_slot.load = issue_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots     <= '0;
            r_fwd_a     <= '0;
            r_fwd_b     <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            // Error capture is independent of the freeze.
            if (issue_valid && issue_wr && (int'(issue_rd) >= NREGS)) begin
                r_err <= 1'b1;
            end
            if (!mem_stall) begin
                // Slot 0 takes the decode instruction or a bubble; the rest shift.
                r_slots <= {r_slots[DEPTH-2:0], w_new_slot};
                r_fwd_a <= w_enter ? w_code_a : FW'(c_FWD_RF);
                r_fwd_b <= w_enter ? w_code_b : FW'(c_FWD_RF);
                if (w_stall && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign stall     = w_stall;
    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Two scoreboards share one stimulus stream: cfg0 uses the
//                default parameters, cfg1 uses NREGS=6, DEPTH=5, LOAD_SLOT=3
//                and a 2-bit stall counter. A timestamp-based model of the
//                in-flight writers predicts every output each cycle; directed
//                literal checks pin the model on the key scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0, issue_wr = 1'b0, issue_load = 1'b0;
    logic [2:0] issue_rd = '0;
    logic       src_a_valid = 1'b0, src_b_valid = 1'b0;
    logic [2:0] src_a = '0, src_b = '0;
    logic       mem_stall = 1'b0, flush = 1'b0;

    logic        stall0, stall1, err0, err1;
    logic [1:0]  fwd_a0, fwd_b0;
    logic [2:0]  fwd_a1, fwd_b1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_load(issue_load), .src_a_valid(src_a_valid),
        .src_b_valid(src_b_valid), .src_a(src_a), .src_b(src_b),
        .mem_stall(mem_stall), .flush(flush), .stall(stall0), .fwd_a(fwd_a0),
        .fwd_b(fwd_b0), .stall_cnt(cnt0), .err(err0)
    );

    hazard_scoreboard #(.NREGS(6), .DEPTH(5), .LOAD_SLOT(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_load(issue_load), .src_a_valid(src_a_valid),
        .src_b_valid(src_b_valid), .src_a(src_a), .src_b(src_b),
        .mem_stall(mem_stall), .flush(flush), .stall(stall1), .fwd_a(fwd_a1),
        .fwd_b(fwd_b1), .stall_cnt(cnt1), .err(err1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Each entered writer is stamped with the advance count at its entry;
    // its current slot is (advances so far) - stamp.
    typedef struct {
        int rd;
        bit ld;
        int stamp;
    } ent_t;

    ent_t hist [2][16];
    int   nent [2] = '{0, 0};
    int   wp   [2] = '{0, 0};
    int   nadv [2] = '{0, 0};
    int   m_fa [2] = '{0, 0};
    int   m_fb [2] = '{0, 0};
    int   m_cnt[2] = '{0, 0};
    int   m_err[2] = '{0, 0};
    int   cfg_nregs[2] = '{8, 6};
    int   cfg_depth[2] = '{3, 5};
    int   cfg_ls   [2] = '{2, 3};
    int   cfg_cmax [2] = '{65535, 3};
    bit   started = 1'b0;

    function automatic void youngest(input int c, input bit sv, input int src,
                                     output bit hit, output int slot, output bit ld);
        hit = 1'b0; slot = 0; ld = 1'b0;
        if (sv) begin
            for (int k = 0; k < nent[c]; k++) begin
                ent_t e;
                e = hist[c][(wp[c] - 1 - k) & 15];
                if (!hit && e.rd == src && (nadv[c] - e.stamp) <= cfg_depth[c] - 1) begin
                    hit  = 1'b1;
                    slot = nadv[c] - e.stamp;
                    ld   = e.ld;
                end
            end
        end
    endfunction

    function automatic int code_of(input int c, input bit hit, input int slot);
        return (hit && slot + 1 <= cfg_depth[c] - 1) ? slot + 1 : 0;
    endfunction

    always @(negedge clk) begin
        bit ha, hb, la, lb, st, enter;
        int sa, sb;
        for (int c = 0; c < 2; c++) begin
            youngest(c, src_a_valid, int'(src_a), ha, sa, la);
            youngest(c, src_b_valid, int'(src_b), hb, sb, lb);
            st = issue_valid && !flush &&
                 ((ha && sa + 1 < (la ? cfg_ls[c] : 1)) ||
                  (hb && sb + 1 < (lb ? cfg_ls[c] : 1)));
            if (started) begin
                chk($sformatf("stall_c%0d", c), (c == 0) ? 32'(stall0) : 32'(stall1), 32'(st));
                chk($sformatf("fwd_a_c%0d", c), (c == 0) ? 32'(fwd_a0) : 32'(fwd_a1), m_fa[c]);
                chk($sformatf("fwd_b_c%0d", c), (c == 0) ? 32'(fwd_b0) : 32'(fwd_b1), m_fb[c]);
                chk($sformatf("cnt_c%0d", c),   (c == 0) ? 32'(cnt0)   : 32'(cnt1),   m_cnt[c]);
                chk($sformatf("err_c%0d", c),   (c == 0) ? 32'(err0)   : 32'(err1),   m_err[c]);
            end
            if (rst) begin
                nent[c] = 0; m_fa[c] = 0; m_fb[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
            end else begin
                if (issue_valid && issue_wr && int'(issue_rd) >= cfg_nregs[c]) m_err[c] = 1;
                if (!mem_stall) begin
                    if (st && m_cnt[c] < cfg_cmax[c]) m_cnt[c]++;
                    enter   = issue_valid && !st && !flush;
                    m_fa[c] = enter ? code_of(c, ha, sa) : 0;
                    m_fb[c] = enter ? code_of(c, hb, sb) : 0;
                    nadv[c]++;
                    if (enter && issue_wr) begin
                        hist[c][wp[c] & 15] = '{int'(issue_rd), issue_load, nadv[c]};
                        wp[c]++;
                        if (nent[c] < 16) nent[c]++;
                    end
                end
            end
        end
        if (rst) started = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input bit iv, input bit wr, input int rd, input bit ld,
                       input bit av, input int a, input bit bv, input int b);
        issue_valid = iv; issue_wr = wr; issue_rd = 3'(rd); issue_load = ld;
        src_a_valid = av; src_a = 3'(a); src_b_valid = bv; src_b = 3'(b);
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        mem_stall = 1'b0; flush = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        idle(0);
        #1;
        chk("rst_fwd_a", fwd_a0, 0); chk("rst_fwd_b", fwd_b0, 0);
        chk("rst_cnt", cnt0, 0);     chk("rst_err", err1, 0);
        chk("rst_stall", stall0, 0);

        // ALU producer r3 directly before its consumer
        drv(1, 1, 3, 0, 0, 0, 0, 0); step();
        drv(1, 1, 4, 0, 1, 3, 0, 0); #1 chk("alu_nostall", stall0, 0);
        step(); chk("alu_fwd1", fwd_a0, 1);
        // one independent instruction between
        drv(1, 1, 3, 0, 0, 0, 0, 0); step();
        drv(1, 1, 6, 0, 0, 0, 0, 0); step();
        drv(1, 1, 4, 0, 1, 3, 0, 0); step();
        chk("alu_fwd2", fwd_a0, 2);
        // two between: register file for DEPTH=3, slot 3 for DEPTH=5
        drv(1, 1, 3, 0, 0, 0, 0, 0); step();
        drv(1, 1, 6, 0, 0, 0, 0, 0); step();
        drv(1, 1, 6, 0, 0, 0, 0, 0); step();
        drv(1, 1, 4, 0, 1, 3, 0, 0); step();
        chk("alu_fwd_rf", fwd_a0, 0); chk("alu_fwd_d5", fwd_a1, 3);
        idle(6);

        // load-use on src_b
        drv(1, 1, 2, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 1, 2); #1 chk("lu_stall", stall0, 1);
        step(); #1 chk("lu_bubble", fwd_b0, 0); chk("lu_stall_end", stall0, 0);
        step(); chk("lu_fwd", fwd_b0, 2); chk("lu_cnt", cnt0, 1);
        idle(6);

        // two writers of r5, youngest wins
        drv(1, 1, 5, 0, 0, 0, 0, 0); step();
        drv(1, 1, 5, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 1, 5, 0, 0); step();
        chk("young_fwd", fwd_a0, 1);
        idle(6);

        // load-use frozen by mem_stall
        do_reset();
        drv(1, 1, 2, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 1, 2); mem_stall = 1'b1;
        repeat (4) step();
        #1 chk("ms_stall", stall0, 1); chk("ms_cnt", cnt0, 0); chk("ms_fwd", fwd_b0, 0);
        mem_stall = 1'b0;
        step(); #1 chk("ms_rel_stall", stall0, 0);
        step(); chk("ms_fwd2", fwd_b0, 2); chk("ms_cnt1", cnt0, 1);
        idle(6);

        // flush with a hazardous decode instruction
        drv(1, 1, 2, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 1, 2); flush = 1'b1;
        #1 chk("fl_stall0", stall0, 0); chk("fl_stall1", stall1, 0);
        step(); chk("fl_fwd", fwd_b0, 0);
        idle(6);

        // DEPTH=5, LOAD_SLOT=3: two stall cycles then forward 3
        do_reset();
        drv(1, 1, 1, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 1, 1, 0, 0); #1 chk("d5_stall_a", stall1, 1);
        step(); #1 chk("d5_stall_b", stall1, 1);
        step(); #1 chk("d5_stall_c", stall1, 0);
        step(); chk("d5_fwd", fwd_a1, 3); chk("d5_cnt", cnt1, 2);
        // out-of-range destination
        drv(1, 1, 7, 0, 0, 0, 0, 0); step();
        idle(0); chk("err_set", err1, 1); chk("err_none", err0, 0);
        idle(3); chk("err_sticky", err1, 1);
        // 2-bit counter saturates
        drv(1, 1, 1, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 1, 1, 0, 0); repeat (3) step();
        chk("sat_cnt", cnt1, 3);
        drv(1, 1, 1, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 1, 1, 0, 0); repeat (3) step();
        chk("sat_hold", cnt1, 3);
        // reset while a load-use stall is frozen by mem_stall
        drv(1, 1, 1, 1, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 1, 1, 0, 0); mem_stall = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; idle(0); #1;
        chk("rst_ms_cnt", cnt1, 0); chk("rst_ms_err", err1, 0);
        chk("rst_ms_fwd", fwd_a1, 0); chk("rst_ms_stall", stall1, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
